// File: rtl/nibble_tx.sv
// Byte-to-nibble transmitter: takes WIDTH-bit words over valid/ready and
// streams them out as framed 4-bit nibbles, counting completed words.
module nibble_tx #(
    parameter int WIDTH     = 8,
    parameter int LSB_FIRST = 1,
    parameter int CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [3:0]           nib_out,
    output logic                 nib_valid,
    output logic                 nib_first,
    output logic                 nib_last,
    input  logic                 nib_ready,
    output logic [CNT_WIDTH-1:0] word_cnt
);

    localparam int NWORDS = WIDTH / 4;
    localparam int IDXW   = (NWORDS > 1) ? $clog2(NWORDS) : 1;

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

    state_t               state, state_n;
    logic [IDXW-1:0]      idx, idx_n;
    logic [WIDTH-1:0]     hold, hold_n;
    logic [CNT_WIDTH-1:0] cnt_n;
    logic                 accept;
    logic                 xfer;
    logic [3:0]           nib_sel;

    assign nib_valid = (state == SEND);
    assign nib_first = nib_valid && (idx == '0);
    assign nib_last  = nib_valid && (idx == IDXW'(NWORDS - 1));
    assign xfer      = nib_valid && nib_ready;

    // Ready reopens on the last-nibble transfer so back-to-back words have no bubble.
    assign in_ready  = !rst && ((state == IDLE) || (xfer && nib_last));
    assign accept    = in_valid && in_ready;

    always_comb begin
        nib_sel = '0;
        for (int unsigned i = 0; i < NWORDS; i++) begin
            if (idx == IDXW'(i)) begin
                nib_sel = (LSB_FIRST != 0) ? hold[4*i +: 4] : hold[WIDTH-4-4*i +: 4];
            end
        end
    end

    assign nib_out = nib_sel;

    always_comb begin
        state_n = state;
        idx_n   = idx;
        hold_n  = hold;
        cnt_n   = word_cnt;
        if (xfer && nib_last) begin
            cnt_n = word_cnt + CNT_WIDTH'(1);
        end
        if (accept) begin
            hold_n  = in_data;
            idx_n   = '0;
            state_n = SEND;
        end else if (xfer) begin
            if (nib_last) begin
                state_n = IDLE;
            end else begin
                idx_n = idx + IDXW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            idx      <= '0;
            hold     <= '0;
            word_cnt <= '0;
        end else begin
            state    <= state_n;
            idx      <= idx_n;
            hold     <= hold_n;
            word_cnt <= cnt_n;
        end
    end

endmodule

// File: tb/tb_nibble_tx.sv
// Directed bench for nibble_tx: default config, 16-bit MSB-first, and a
// 2-bit counter instance, with hand-computed expected nibbles and counts.
module tb_nibble_tx;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    // Default instance: WIDTH=8, LSB_FIRST=1, CNT_WIDTH=8
    logic [7:0]  a_data;
    logic        a_valid, a_ready, a_nready;
    logic [3:0]  a_nib;
    logic        a_nvalid, a_first, a_last;
    logic [7:0]  a_cnt;

    // WIDTH=16, LSB_FIRST=0
    logic [15:0] b_data;
    logic        b_valid, b_ready, b_nready;
    logic [3:0]  b_nib;
    logic        b_nvalid, b_first, b_last;
    logic [7:0]  b_cnt;

    // CNT_WIDTH=2
    logic [7:0]  c_data;
    logic        c_valid, c_ready, c_nready;
    logic [3:0]  c_nib;
    logic        c_nvalid, c_first, c_last;
    logic [1:0]  c_cnt;

    nibble_tx dut (
        .clk(clk), .rst(rst), .in_data(a_data), .in_valid(a_valid), .in_ready(a_ready),
        .nib_out(a_nib), .nib_valid(a_nvalid), .nib_first(a_first), .nib_last(a_last),
        .nib_ready(a_nready), .word_cnt(a_cnt)
    );

    nibble_tx #(.WIDTH(16), .LSB_FIRST(0), .CNT_WIDTH(8)) dut16 (
        .clk(clk), .rst(rst), .in_data(b_data), .in_valid(b_valid), .in_ready(b_ready),
        .nib_out(b_nib), .nib_valid(b_nvalid), .nib_first(b_first), .nib_last(b_last),
        .nib_ready(b_nready), .word_cnt(b_cnt)
    );

    nibble_tx #(.WIDTH(8), .LSB_FIRST(1), .CNT_WIDTH(2)) dutc (
        .clk(clk), .rst(rst), .in_data(c_data), .in_valid(c_valid), .in_ready(c_ready),
        .nib_out(c_nib), .nib_valid(c_nvalid), .nib_first(c_first), .nib_last(c_last),
        .nib_ready(c_nready), .word_cnt(c_cnt)
    );

    int total  = 0;
    int passed = 0;
    int failed = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one edge and settle; checks and input changes happen here.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [3:0] bb_nib [6];
        logic [7:0] bb_word [3];
        logic [3:0] msb_nib [4];
        logic [1:0] wrap_cnt [5];

        bb_nib   = '{4'h2, 4'h1, 4'h4, 4'h3, 4'h6, 4'h5};
        bb_word  = '{8'h12, 8'h34, 8'h56};
        msb_nib  = '{4'hB, 4'hE, 4'hE, 4'hF};
        wrap_cnt = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

        a_data = '0; a_valid = 1'b0; a_nready = 1'b0;
        b_data = '0; b_valid = 1'b0; b_nready = 1'b0;
        c_data = '0; c_valid = 1'b0; c_nready = 1'b0;

        // Reset held for 3 cycles with random inputs
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            a_data   = 8'($urandom);
            a_valid  = 1'($urandom);
            a_nready = 1'($urandom);
            tick();
            chk("rst_nib_valid", 32'(a_nvalid), 0);
            chk("rst_nib_out",   32'(a_nib),    0);
            chk("rst_word_cnt",  32'(a_cnt),    0);
            chk("rst_in_ready",  32'(a_ready),  0);
        end
        rst = 1'b0;
        a_valid = 1'b0;
        a_nready = 1'b0;
        #1;
        chk("in_ready_after_rst", 32'(a_ready), 1);

        // Single word 0xA5
        a_data = 8'hA5; a_valid = 1'b1; a_nready = 1'b1;
        tick();
        a_valid = 1'b0;
        chk("a5_valid0", 32'(a_nvalid), 1);
        chk("a5_nib0",   32'(a_nib),    'h5);
        chk("a5_first0", 32'(a_first),  1);
        chk("a5_last0",  32'(a_last),   0);
        chk("a5_rdy0",   32'(a_ready),  0);
        tick();
        chk("a5_valid1", 32'(a_nvalid), 1);
        chk("a5_nib1",   32'(a_nib),    'hA);
        chk("a5_first1", 32'(a_first),  0);
        chk("a5_last1",  32'(a_last),   1);
        chk("a5_rdy1",   32'(a_ready),  1);
        tick();
        chk("a5_idle",   32'(a_nvalid), 0);
        chk("a5_cnt",    32'(a_cnt),    1);
        chk("a5_rdy2",   32'(a_ready),  1);

        // Back-to-back 0x12, 0x34, 0x56
        a_data = bb_word[0]; a_valid = 1'b1;
        tick();
        for (int k = 0; k < 6; k++) begin
            chk("bb_valid", 32'(a_nvalid), 1);
            chk("bb_nib",   32'(a_nib),    32'(bb_nib[k]));
            chk("bb_first", 32'(a_first),  (k % 2 == 0) ? 1 : 0);
            chk("bb_last",  32'(a_last),   (k % 2 == 1) ? 1 : 0);
            chk("bb_rdy",   32'(a_ready),  (k % 2 == 1) ? 1 : 0);
            if (k % 2 == 1) begin
                if (k == 5) a_valid = 1'b0;
                else        a_data = bb_word[(k + 1) / 2];
            end
            tick();
        end
        chk("bb_idle", 32'(a_nvalid), 0);
        chk("bb_cnt",  32'(a_cnt),    4);

        // Backpressure on 0xC3
        a_data = 8'hC3; a_valid = 1'b1; a_nready = 1'b1;
        tick();
        a_valid = 1'b1;
        a_data = 8'h99;
        a_nready = 1'b0;
        for (int s = 0; s < 4; s++) begin
            #1;
            chk("bp_nib",   32'(a_nib),    'h3);
            chk("bp_first", 32'(a_first),  1);
            chk("bp_valid", 32'(a_nvalid), 1);
            chk("bp_rdy",   32'(a_ready),  0);
            tick();
        end
        a_valid = 1'b0;
        a_nready = 1'b1;
        #1;
        chk("bp_nib_release", 32'(a_nib), 'h3);
        tick();
        chk("bp_nib_hi",  32'(a_nib),  'hC);
        chk("bp_last_hi", 32'(a_last), 1);
        tick();
        chk("bp_idle", 32'(a_nvalid), 0);
        chk("bp_cnt",  32'(a_cnt),    5);

        // Reset while the second nibble of 0x7E is pending
        a_data = 8'h7E; a_valid = 1'b1; a_nready = 1'b1;
        tick();
        a_valid = 1'b0;
        chk("mr_nib0", 32'(a_nib), 'hE);
        tick();
        a_nready = 1'b0;
        chk("mr_nib1", 32'(a_nib), 'h7);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk("mr_valid", 32'(a_nvalid), 0);
        chk("mr_cnt",   32'(a_cnt),    0);
        chk("mr_rdy",   32'(a_ready),  1);

        // MSB-first, WIDTH=16, word 0xBEEF
        b_data = 16'hBEEF; b_valid = 1'b1; b_nready = 1'b1;
        tick();
        b_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk("msb_valid", 32'(b_nvalid), 1);
            chk("msb_nib",   32'(b_nib),    32'(msb_nib[k]));
            chk("msb_first", 32'(b_first),  (k == 0) ? 1 : 0);
            chk("msb_last",  32'(b_last),   (k == 3) ? 1 : 0);
            tick();
        end
        chk("msb_idle", 32'(b_nvalid), 0);
        chk("msb_cnt",  32'(b_cnt),    1);

        // Counter wrap with CNT_WIDTH=2
        c_nready = 1'b1;
        for (int w = 0; w < 5; w++) begin
            c_data = 8'(8'h10 + w);
            c_valid = 1'b1;
            tick();
            c_valid = 1'b0;
            tick();
            tick();
            chk("wrap_cnt", 32'(c_cnt), 32'(wrap_cnt[w]));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
